// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types for the program-counter sequencer.
//   op_e    : 2-bit step operation (COND, JUMP, CALL, RET), encoded as on rx_op.
//   state_e : sequencer FSM states (IDLE accepts a step, EXEC resolves it).
package pc_seq_pkg;

  typedef enum logic [1:0] {
    OP_COND = 2'd0,
    OP_JUMP = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/pc_seq_stack.sv
// pc_seq_stack: small LIFO holding return addresses for CALL/RET.
// Ports:
//   clk       in   clock, rising edge
//   srst      in   synchronous reset, active-high (empties the stack)
//   push      in   write push_data on top (ignored when full)
//   pop       in   discard top entry (ignored when empty)
//   push_data in   WIDTH-bit value to push
//   full      out  DEPTH entries held
//   empty     out  no entries held
//   top       out  most recently pushed entry (valid when !empty)
// DEPTH must be a power of two, >= 2.
module pc_seq_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] top
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count_reg;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  // With a power-of-two depth the low count bits address the next free slot;
  // count==DEPTH wraps to 0, which is harmless because push is blocked when full.
  assign wr_idx  = count_reg[AW-1:0];
  assign top_idx = count_reg[AW-1:0] - AW'(1);

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign top   = mem[top_idx];

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (push && !full) begin
      count_reg <= count_reg + CNT_W'(1);
    end else if (pop && !empty) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Storage carries no reset; a stray write on a reset edge is unreachable
  // because the count is cleared at the same time.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: holds the program counter and resolves one sequencing step
// (conditional branch, jump, call, return) per accepted strobe.
// Ports:
//   aclk, areset        clock / synchronous active-high reset
//   rx_enable           global enable for register writes and strobes
//   rx_write_branch     load branch register from rx_branch
//   rx_write_flags      load flag register from rx_input_flags
//   rx_strobe, rx_op    step request and its operation (accepted when tx_ready)
//   rx_input_flags      new flag value
//   rx_check_flags      flags that must all be set for COND to be taken
//   rx_branch           new branch target
//   tx_program_counter  current PC (registered)
//   tx_ready            idle, next strobe accepted
//   tx_fault            sticky stack overflow/underflow
// Build option: PC_SEQUENCER_CALL_STACK_EN enables the return stack. Without it
// CALL acts as JUMP, RET advances PC by one and tx_fault is constant 0.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter int              FLAG_W      = 4,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              rx_enable,
  input  logic              rx_write_branch,
  input  logic              rx_write_flags,
  input  logic              rx_strobe,
  input  logic [1:0]        rx_op,
  input  logic [FLAG_W-1:0] rx_input_flags,
  input  logic [FLAG_W-1:0] rx_check_flags,
  input  logic [PC_W-1:0]   rx_branch,
  output logic [PC_W-1:0]   tx_program_counter,
  output logic              tx_ready,
  output logic              tx_fault
);

  state_e            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next, pc_inc;
  logic [PC_W-1:0]   branch_reg, branch_cap_reg;
  logic [FLAG_W-1:0] flag_reg, flag_cap_reg, check_cap_reg;
  op_e               op_cap_reg;
  logic              accept;
  logic              taken;

`ifdef PC_SEQUENCER_CALL_STACK_EN
  logic            fault_reg, fault_next;
  logic            push, pop, full, empty;
  logic [PC_W-1:0] top;

  pc_seq_stack #(
    .DEPTH(STACK_DEPTH),
    .WIDTH(PC_W)
  ) u_stack (
    .clk      (aclk),
    .srst     (areset),
    .push     (push),
    .pop      (pop),
    .push_data(pc_inc),
    .full     (full),
    .empty    (empty),
    .top      (top)
  );

  assign tx_fault = fault_reg;
`else
  logic unused_depth;
  assign unused_depth = ^STACK_DEPTH;
  assign tx_fault     = 1'b0;
`endif

  assign tx_ready           = (state_reg == ST_IDLE);
  assign tx_program_counter = pc_reg;
  assign accept             = rx_enable && rx_strobe && tx_ready;
  assign pc_inc             = pc_reg + PC_W'(1);
  // An empty check mask is trivially satisfied, so COND with check 0 always branches.
  assign taken              = ((flag_cap_reg & check_cap_reg) == check_cap_reg);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= RESET_PC;
      flag_reg       <= '0;
      branch_reg     <= '0;
      flag_cap_reg   <= '0;
      check_cap_reg  <= '0;
      branch_cap_reg <= '0;
      op_cap_reg     <= OP_COND;
`ifdef PC_SEQUENCER_CALL_STACK_EN
      fault_reg      <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
`ifdef PC_SEQUENCER_CALL_STACK_EN
      fault_reg <= fault_next;
`endif
      if (rx_enable && rx_write_branch) branch_reg <= rx_branch;
      if (rx_enable && rx_write_flags)  flag_reg   <= rx_input_flags;
      // Captures read the registers before any coincident write lands.
      if (accept) begin
        op_cap_reg     <= op_e'(rx_op);
        check_cap_reg  <= rx_check_flags;
        flag_cap_reg   <= flag_reg;
        branch_cap_reg <= branch_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
`ifdef PC_SEQUENCER_CALL_STACK_EN
    fault_next = fault_reg;
    push       = 1'b0;
    pop        = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_IDLE;
        case (op_cap_reg)
          OP_COND: pc_next = taken ? branch_cap_reg : pc_inc;
          OP_JUMP: pc_next = branch_cap_reg;
`ifdef PC_SEQUENCER_CALL_STACK_EN
          OP_CALL: begin
            if (full) begin
              pc_next    = pc_inc;
              fault_next = 1'b1;
            end else begin
              push    = 1'b1;
              pc_next = branch_cap_reg;
            end
          end
          OP_RET: begin
            if (empty) begin
              pc_next    = pc_inc;
              fault_next = 1'b1;
            end else begin
              pop     = 1'b1;
              pc_next = top;
            end
          end
`else
          OP_CALL: pc_next = branch_cap_reg;
          OP_RET:  pc_next = pc_inc;
`endif
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        rx_enable, rx_write_branch, rx_write_flags, rx_strobe;
  logic [1:0]  rx_op;
  logic [3:0]  rx_input_flags, rx_check_flags;
  logic [15:0] rx_branch;
  logic [15:0] tx_program_counter;
  logic        tx_ready, tx_fault;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_pc;

  localparam logic [1:0] COND = 2'd0, JUMP = 2'd1, CALL = 2'd2, RET = 2'd3;

`ifdef PC_SEQUENCER_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  always #5 aclk = ~aclk;

  pc_sequencer #(
    .PC_W(16), .FLAG_W(4), .STACK_DEPTH(4), .RESET_PC(16'h0000)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .rx_enable         (rx_enable),
    .rx_write_branch   (rx_write_branch),
    .rx_write_flags    (rx_write_flags),
    .rx_strobe         (rx_strobe),
    .rx_op             (rx_op),
    .rx_input_flags    (rx_input_flags),
    .rx_check_flags    (rx_check_flags),
    .rx_branch         (rx_branch),
    .tx_program_counter(tx_program_counter),
    .tx_ready          (tx_ready),
    .tx_fault          (tx_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr_branch(input logic [15:0] b);
    rx_enable = 1'b1; rx_write_branch = 1'b1; rx_branch = b;
    @(negedge aclk);
    rx_write_branch = 1'b0;
  endtask

  task automatic wr_flags(input logic [3:0] f);
    rx_enable = 1'b1; rx_write_flags = 1'b1; rx_input_flags = f;
    @(negedge aclk);
    rx_write_flags = 1'b0;
  endtask

  task automatic step(input string tag, input logic [1:0] op, input logic [3:0] chkf,
                      input logic [15:0] new_pc);
    rx_enable = 1'b1; rx_strobe = 1'b1; rx_op = op; rx_check_flags = chkf;
    @(negedge aclk);
    rx_strobe = 1'b0;
    chk({tag, "_busy"}, 32'(tx_ready), 32'd0);
    chk({tag, "_hold"}, 32'(tx_program_counter), 32'(exp_pc));
    @(negedge aclk);
    chk({tag, "_rdy"}, 32'(tx_ready), 32'd1);
    chk({tag, "_pc"}, 32'(tx_program_counter), 32'(new_pc));
    $display("step %s op=%0d check=%b pc=%04h exp=%04h fault=%0b",
             tag, op, chkf, tx_program_counter, new_pc, tx_fault);
    exp_pc = new_pc;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    exp_pc = 16'h0000;
  endtask

  logic [15:0] ret_tbl [4];
  logic [15:0] pc_tmp;

  initial begin
    areset = 1'b0; rx_enable = 1'b0; rx_write_branch = 1'b0; rx_write_flags = 1'b0;
    rx_strobe = 1'b0; rx_op = 2'd0; rx_input_flags = 4'd0; rx_check_flags = 4'd0;
    rx_branch = 16'd0; exp_pc = 16'd0;
    @(negedge aclk);
    do_reset();
    chk("rst_pc", 32'(tx_program_counter), 32'h0);
    chk("rst_rdy", 32'(tx_ready), 32'd1);
    chk("rst_fault", 32'(tx_fault), 32'd0);

    // 1: flags reset to 0, check 0001 -> not taken
    step("t1_cond_nt", COND, 4'b0001, 16'h0001);

    // 2: taken / not taken with flags 1011
    wr_flags(4'b1011);
    wr_branch(16'h0200);
    step("t2_cond_tk", COND, 4'b0011, 16'h0200);
    step("t2_cond_nt", COND, 4'b0100, 16'h0201);
    step("t2_cond_zero", COND, 4'b0000, 16'h0200);

    // Strobe with enable low is ignored
    rx_enable = 1'b0; rx_strobe = 1'b1; rx_op = JUMP;
    @(negedge aclk);
    chk("en_off_rdy", 32'(tx_ready), 32'd1);
    @(negedge aclk);
    rx_strobe = 1'b0;
    chk("en_off_pc", 32'(tx_program_counter), 32'(exp_pc));

    // 3: coincident write_branch, JUMP uses the old branch value
    wr_branch(16'h0100);
    rx_write_branch = 1'b1; rx_branch = 16'h0300;
    rx_enable = 1'b1; rx_strobe = 1'b1; rx_op = JUMP;
    @(negedge aclk);
    rx_write_branch = 1'b0; rx_strobe = 1'b0;
    chk("t3_busy", 32'(tx_ready), 32'd0);
    @(negedge aclk);
    chk("t3_old_pc", 32'(tx_program_counter), 32'h0100);
    exp_pc = 16'h0100;
    step("t3_new", JUMP, 4'b0000, 16'h0300);

    // 4: strobe held high, COND not taken (check 1111 vs flags 1011)
    rx_strobe = 1'b1; rx_op = COND; rx_check_flags = 4'b1111;
    for (int i = 1; i <= 6; i++) begin
      @(negedge aclk);
      chk($sformatf("t4_rdy%0d", i), 32'(tx_ready), 32'(i % 2 == 0));
      chk($sformatf("t4_pc%0d", i), 32'(tx_program_counter), 32'(16'h0300 + 16'(i / 2)));
      $display("hold cycle %0d pc=%04h ready=%0b", i, tx_program_counter, tx_ready);
    end
    rx_strobe = 1'b0;
    exp_pc = 16'h0303;

    // 5: call/return stack
    for (int i = 1; i <= 4; i++) begin
      pc_tmp = exp_pc;
      wr_branch(16'(i) << 12);
      step($sformatf("t5_call%0d", i), CALL, 4'b0000, 16'(i) << 12);
      ret_tbl[i-1] = pc_tmp + 16'd1;
    end
    chk("t5_fault_pre", 32'(tx_fault), 32'd0);
    wr_branch(16'h5000);
    step("t5_call5", CALL, 4'b0000, STACK_EN ? 16'h4001 : 16'h5000);
    chk("t5_fault_ovf", 32'(tx_fault), 32'(STACK_EN));
    for (int i = 3; i >= 0; i--) begin
      step($sformatf("t5_ret%0d", i), RET, 4'b0000, STACK_EN ? ret_tbl[i] : exp_pc + 16'd1);
    end
    step("t5_ret_extra", RET, 4'b0000, exp_pc + 16'd1);
    chk("t5_fault_udf", 32'(tx_fault), 32'(STACK_EN));

    // 6: wrap and reset during EXEC
    wr_branch(16'hFFFF);
    step("t6_jmp_max", JUMP, 4'b0000, 16'hFFFF);
    step("t6_wrap", COND, 4'b1111, 16'h0000);
    wr_branch(16'h1234);
    rx_strobe = 1'b1; rx_op = JUMP;
    @(negedge aclk);
    rx_strobe = 1'b0;
    chk("t6_exec", 32'(tx_ready), 32'd0);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    exp_pc = 16'h0000;
    chk("t6_rst_pc", 32'(tx_program_counter), 32'h0);
    chk("t6_rst_rdy", 32'(tx_ready), 32'd1);
    chk("t6_rst_fault", 32'(tx_fault), 32'd0);
    @(negedge aclk);
    chk("t6_rst_hold", 32'(tx_program_counter), 32'h0);
    step("t6_flags_cleared", COND, 4'b0001, 16'h0001);
    step("t6_branch_cleared", JUMP, 4'b0000, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
